// File: rtl/wb_writer_if.sv
// Writeback bus: M-stage result inputs, long-latency handshake and register-file write port.
interface wb_writer_if #(
    parameter int XLEN = 32
);
    logic            M_valid_i;
    logic            M_need_dstE_i;
    logic [4:0]      M_dstE_i;
    logic [1:0]      M_sel_i;
    logic [XLEN-1:0] M_alu_i;
    logic [XLEN-1:0] M_load_raw_i;
    logic [2:0]      M_funct3_i;
    logic [1:0]      M_addr_lo_i;
    logic [XLEN-1:0] M_pc_i;
    logic            LL_valid_i;
    logic            LL_ready_o;
    logic [4:0]      LL_dst_i;
    logic [XLEN-1:0] LL_data_i;
    logic            stall_o;
    logic            MD_need_dstE_o;
    logic [4:0]      MD_dstE_o;
    logic [XLEN-1:0] MD_data_o;

    modport master (
        output M_valid_i, M_need_dstE_i, M_dstE_i, M_sel_i, M_alu_i, M_load_raw_i,
               M_funct3_i, M_addr_lo_i, M_pc_i, LL_valid_i, LL_dst_i, LL_data_i,
        input  LL_ready_o, stall_o, MD_need_dstE_o, MD_dstE_o, MD_data_o
    );

    modport slave (
        input  M_valid_i, M_need_dstE_i, M_dstE_i, M_sel_i, M_alu_i, M_load_raw_i,
               M_funct3_i, M_addr_lo_i, M_pc_i, LL_valid_i, LL_dst_i, LL_data_i,
        output LL_ready_o, stall_o, MD_need_dstE_o, MD_dstE_o, MD_data_o
    );
endinterface

// File: rtl/wb_writer.sv
// Writeback writer: formats M-stage results, merges long-latency results via a 2-entry FIFO.
// Optional retire counter output enabled by macro WB_RETIRE_CNT_EN.
module wb_writer #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    wb_writer_if.slave  wb
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0] retire_cnt_o
`endif
);
    localparam int SW = $clog2(STARVE_LIMIT) + 1;

    typedef struct packed {
        logic [4:0]      dst;
        logic [XLEN-1:0] data;
    } ll_entry_t;

    ll_entry_t       r_fifo [2];
    logic            r_head;
    logic [1:0]      r_count;
    logic [SW-1:0]   r_starve;
    logic            r_stall;
    logic            r_md_need;
    logic [4:0]      r_md_dst;
    logic [XLEN-1:0] r_md_data;

    logic            w_busy;
    logic            w_push;
    logic            w_pop;
    logic            w_tail;
    ll_entry_t       w_head;
    logic [1:0]      w_count_nxt;
    logic [SW-1:0]   w_starve_nxt;
    logic [XLEN-1:0] w_shifted;
    logic [15:0]     w_half_s;
    logic [XLEN-1:0] w_load;
    logic [XLEN-1:0] w_result;

    assign wb.LL_ready_o = (r_count != 2'd2);
    assign w_push = wb.LL_valid_i && wb.LL_ready_o;
    assign w_busy = wb.M_valid_i && wb.M_need_dstE_i && (wb.M_dstE_i != 5'd0) && !r_stall;
    assign w_pop  = !w_busy && (r_count != 2'd0);
    assign w_head = r_fifo[r_head];
    assign w_tail = r_head ^ r_count[0];

    assign w_shifted = wb.M_load_raw_i >> {wb.M_addr_lo_i, 3'b000};
    assign w_half_s  = wb.M_addr_lo_i[1] ? wb.M_load_raw_i[31:16] : wb.M_load_raw_i[15:0];

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        w_load = wb.M_load_raw_i;
        case (wb.M_funct3_i)
            3'b000:  w_load = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load = {{(XLEN-16){w_half_s[15]}}, w_half_s};
            3'b100:  w_load = w_shifted & XLEN'(8'hFF);
            3'b101:  w_load = w_shifted & XLEN'(16'hFFFF);
            default: w_load = wb.M_load_raw_i;
        endcase
    end

    always_comb begin
        w_result = wb.M_alu_i;
        case (wb.M_sel_i)
            2'b01:   w_result = w_load;
            2'b10:   w_result = wb.M_pc_i + XLEN'(4);
            default: w_result = wb.M_alu_i;
        endcase
    end

    always_comb begin
        w_count_nxt  = r_count;
        w_starve_nxt = '0;
        if (w_push && !w_pop)
            w_count_nxt = r_count + 2'd1;
        else if (!w_push && w_pop)
            w_count_nxt = r_count - 2'd1;
        if ((r_count != 2'd0) && !w_pop)
            w_starve_nxt = r_starve + SW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count  <= 2'd0;
            r_head   <= 1'b0;
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else begin
            r_count  <= w_count_nxt;
            r_starve <= w_starve_nxt;
            r_stall  <= (w_starve_nxt == SW'(STARVE_LIMIT - 1));
            if (w_pop)
                r_head <= ~r_head;
        end
    end

    // NOTE: FIFO storage is not reset; r_count alone decides which slots are meaningful.
    always_ff @(posedge clk_i) begin
        if (w_push)
            r_fifo[w_tail] <= '{dst: wb.LL_dst_i, data: wb.LL_data_i};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_md_need <= 1'b0;
            r_md_dst  <= 5'd0;
            r_md_data <= '0;
        end else if (w_busy) begin
            r_md_need <= 1'b1;
            r_md_dst  <= wb.M_dstE_i;
            r_md_data <= w_result;
        end else if (w_pop) begin
            r_md_need <= (w_head.dst != 5'd0);
            r_md_dst  <= w_head.dst;
            r_md_data <= w_head.data;
        end else begin
            r_md_need <= 1'b0;
        end
    end

    assign wb.stall_o        = r_stall;
    assign wb.MD_need_dstE_o = r_md_need;
    assign wb.MD_dstE_o      = r_md_dst;
    assign wb.MD_data_o      = r_md_data;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] r_retire_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_retire_cnt <= 64'd0;
        else if (r_md_need)
            r_retire_cnt <= r_retire_cnt + 64'd1;
    end

    assign retire_cnt_o = r_retire_cnt;
`endif
endmodule

// File: tb/tb_wb_writer.sv
// Self-checking bench for wb_writer: vector table for the M-stage mux plus FIFO, starvation and reset sequences.
module tb_wb_writer;
    localparam int XLEN = 32;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    wb_writer_if #(.XLEN(XLEN)) wb_bus ();

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt;
`endif

    wb_writer #(.XLEN(XLEN), .STARVE_LIMIT(8)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .wb    (wb_bus)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt_o (retire_cnt)
`endif
    );

    typedef struct {
        logic        valid;
        logic        need;
        logic [4:0]  dst;
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [31:0] raw;
        logic [2:0]  f3;
        logic [1:0]  alo;
        logic [31:0] pc;
        logic        exp_need;
        logic [4:0]  exp_dst;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        logic        need;
        logic [4:0]  dst;
        logic [31:0] data;
        bit          full;
    } exp_t;

    vec_t vecs [16];
    exp_t sb_q [$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic m_idle();
        wb_bus.M_valid_i     = 1'b0;
        wb_bus.M_need_dstE_i = 1'b0;
        wb_bus.M_dstE_i      = 5'd0;
        wb_bus.M_sel_i       = 2'b00;
        wb_bus.M_alu_i       = 32'h0;
        wb_bus.M_load_raw_i  = 32'h0;
        wb_bus.M_funct3_i    = 3'b010;
        wb_bus.M_addr_lo_i   = 2'd0;
        wb_bus.M_pc_i        = 32'h0;
    endtask

    task automatic m_alu(input logic [4:0] d, input logic [31:0] v);
        m_idle();
        wb_bus.M_valid_i     = 1'b1;
        wb_bus.M_need_dstE_i = 1'b1;
        wb_bus.M_dstE_i      = d;
        wb_bus.M_alu_i       = v;
    endtask

    task automatic ll_set(input logic v, input logic [4:0] d, input logic [31:0] data);
        wb_bus.LL_valid_i = v;
        wb_bus.LL_dst_i   = d;
        wb_bus.LL_data_i  = data;
    endtask

    task automatic exp_push(input logic need, input logic [4:0] d, input logic [31:0] data, input bit full);
        sb_q.push_back('{need: need, dst: d, data: data, full: full});
    endtask

    // Advance one clock and compare the write port against the oldest expectation.
    task automatic step(input string tag);
        exp_t e;
        @(posedge clk_i);
        #1;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got need=%0b", tag, wb_bus.MD_need_dstE_o);
        end else begin
            e = sb_q.pop_front();
            check({tag, ".need"}, 64'(wb_bus.MD_need_dstE_o), 64'(e.need));
            if (e.full) begin
                check({tag, ".dst"}, 64'(wb_bus.MD_dstE_o), 64'(e.dst));
                check({tag, ".data"}, 64'(wb_bus.MD_data_o), 64'(e.data));
            end
        end
    endtask

    initial begin
        //          valid need dst    sel    alu           raw           f3      alo   pc            en    edst   edata
        vecs[0]  = '{1'b1, 1'b1, 5'd5,  2'b00, 32'h00001234, 32'h0,        3'b010, 2'd0, 32'h0,        1'b1, 5'd5,  32'h00001234};
        vecs[1]  = '{1'b1, 1'b1, 5'd6,  2'b01, 32'h0,        32'h80FF7F01, 3'b000, 2'd3, 32'h0,        1'b1, 5'd6,  32'hFFFFFF80};
        vecs[2]  = '{1'b1, 1'b1, 5'd7,  2'b01, 32'h0,        32'h80FF7F01, 3'b101, 2'd2, 32'h0,        1'b1, 5'd7,  32'h000080FF};
        vecs[3]  = '{1'b1, 1'b1, 5'd8,  2'b01, 32'h0,        32'h80FF7F01, 3'b001, 2'd0, 32'h0,        1'b1, 5'd8,  32'h00007F01};
        vecs[4]  = '{1'b1, 1'b1, 5'd9,  2'b01, 32'h0,        32'h80FF7F01, 3'b001, 2'd1, 32'h0,        1'b1, 5'd9,  32'h00007F01};
        vecs[5]  = '{1'b1, 1'b1, 5'd10, 2'b01, 32'h0,        32'h80FF7F01, 3'b100, 2'd1, 32'h0,        1'b1, 5'd10, 32'h0000007F};
        vecs[6]  = '{1'b1, 1'b1, 5'd11, 2'b01, 32'h0,        32'h80FF7F01, 3'b010, 2'd2, 32'h0,        1'b1, 5'd11, 32'h80FF7F01};
        vecs[7]  = '{1'b1, 1'b1, 5'd12, 2'b01, 32'h0,        32'h80FF7F01, 3'b000, 2'd0, 32'h0,        1'b1, 5'd12, 32'h00000001};
        vecs[8]  = '{1'b1, 1'b1, 5'd13, 2'b01, 32'h0,        32'h80FF7F01, 3'b001, 2'd2, 32'h0,        1'b1, 5'd13, 32'hFFFF80FF};
        vecs[9]  = '{1'b1, 1'b1, 5'd14, 2'b01, 32'h0,        32'h80FF7F01, 3'b011, 2'd1, 32'h0,        1'b1, 5'd14, 32'h80FF7F01};
        vecs[10] = '{1'b1, 1'b1, 5'd1,  2'b10, 32'h0,        32'h0,        3'b010, 2'd0, 32'hFFFFFFFC, 1'b1, 5'd1,  32'h00000000};
        vecs[11] = '{1'b1, 1'b1, 5'd2,  2'b10, 32'h0,        32'h0,        3'b010, 2'd0, 32'h00000100, 1'b1, 5'd2,  32'h00000104};
        vecs[12] = '{1'b1, 1'b1, 5'd31, 2'b11, 32'hDEADBEEF, 32'h0,        3'b010, 2'd0, 32'h0,        1'b1, 5'd31, 32'hDEADBEEF};
        vecs[13] = '{1'b1, 1'b1, 5'd0,  2'b00, 32'h11111111, 32'h0,        3'b010, 2'd0, 32'h0,        1'b0, 5'd31, 32'hDEADBEEF};
        vecs[14] = '{1'b0, 1'b1, 5'd3,  2'b00, 32'h22222222, 32'h0,        3'b010, 2'd0, 32'h0,        1'b0, 5'd31, 32'hDEADBEEF};
        vecs[15] = '{1'b1, 1'b0, 5'd4,  2'b00, 32'h33333333, 32'h0,        3'b010, 2'd0, 32'h0,        1'b0, 5'd31, 32'hDEADBEEF};

        m_idle();
        ll_set(1'b0, 5'd0, 32'h0);
        #2;
        check("rst.need",  64'(wb_bus.MD_need_dstE_o), 64'd0);
        check("rst.dst",   64'(wb_bus.MD_dstE_o), 64'd0);
        check("rst.data",  64'(wb_bus.MD_data_o), 64'd0);
        check("rst.stall", 64'(wb_bus.stall_o), 64'd0);
        check("rst.ready", 64'(wb_bus.LL_ready_o), 64'd1);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 16; i++) begin
            wb_bus.M_valid_i     = vecs[i].valid;
            wb_bus.M_need_dstE_i = vecs[i].need;
            wb_bus.M_dstE_i      = vecs[i].dst;
            wb_bus.M_sel_i       = vecs[i].sel;
            wb_bus.M_alu_i       = vecs[i].alu;
            wb_bus.M_load_raw_i  = vecs[i].raw;
            wb_bus.M_funct3_i    = vecs[i].f3;
            wb_bus.M_addr_lo_i   = vecs[i].alo;
            wb_bus.M_pc_i        = vecs[i].pc;
            exp_push(vecs[i].exp_need, vecs[i].exp_dst, vecs[i].exp_data, 1'b1);
            step($sformatf("vec%0d", i));
        end

        // FIFO fills behind a busy pipeline, then drains in order; a push while full is refused.
        m_alu(5'd10, 32'h10); ll_set(1'b1, 5'd7, 32'hAA); exp_push(1'b1, 5'd10, 32'h10, 1'b1); step("arb.c1");
        check("arb.ready1", 64'(wb_bus.LL_ready_o), 64'd1);
        m_alu(5'd11, 32'h11); ll_set(1'b1, 5'd8, 32'hBB); exp_push(1'b1, 5'd11, 32'h11, 1'b1); step("arb.c2");
        check("arb.ready_full", 64'(wb_bus.LL_ready_o), 64'd0);
        m_idle(); ll_set(1'b1, 5'd9, 32'hCC); exp_push(1'b1, 5'd7, 32'hAA, 1'b1); step("arb.pop7");
        check("arb.ready_after_pop", 64'(wb_bus.LL_ready_o), 64'd1);
        ll_set(1'b0, 5'd0, 32'h0); exp_push(1'b1, 5'd8, 32'hBB, 1'b1); step("arb.pop8");
        exp_push(1'b0, 5'd8, 32'hBB, 1'b1); step("arb.refused");

        // One entry: simultaneous push and pop keeps order.
        m_alu(5'd25, 32'h25); ll_set(1'b1, 5'd20, 32'h20); exp_push(1'b1, 5'd25, 32'h25, 1'b1); step("pp.c1");
        m_idle(); ll_set(1'b1, 5'd21, 32'h21); exp_push(1'b1, 5'd20, 32'h20, 1'b1); step("pp.pop20");
        check("pp.ready", 64'(wb_bus.LL_ready_o), 64'd1);
        ll_set(1'b0, 5'd0, 32'h0); exp_push(1'b1, 5'd21, 32'h21, 1'b1); step("pp.pop21");
        exp_push(1'b0, 5'd21, 32'h21, 1'b1); step("pp.idle");

        // LL entry to x0 is consumed without a write.
        m_alu(5'd26, 32'h26); ll_set(1'b1, 5'd0, 32'h55); exp_push(1'b1, 5'd26, 32'h26, 1'b1); step("x0ll.push");
        m_idle(); ll_set(1'b0, 5'd0, 32'h0); exp_push(1'b0, 5'd0, 32'h0, 1'b0); step("x0ll.pop");
        exp_push(1'b0, 5'd0, 32'h0, 1'b0); step("x0ll.idle");
        m_alu(5'd27, 32'h27); exp_push(1'b1, 5'd27, 32'h27, 1'b1); step("x0ll.after");

        // Starvation: head waits 7 cycles, then a one-cycle stall drains it.
        m_alu(5'd12, 32'h1200); ll_set(1'b1, 5'd9, 32'h99); exp_push(1'b1, 5'd12, 32'h1200, 1'b1); step("stv.push");
        ll_set(1'b0, 5'd0, 32'h0);
        check("stv.stall_push", 64'(wb_bus.stall_o), 64'd0);
        for (int i = 1; i <= 7; i++) begin
            m_alu(5'(12 + i), 32'h1200 + 32'(i));
            exp_push(1'b1, 5'(12 + i), 32'h1200 + 32'(i), 1'b1);
            step($sformatf("stv.wait%0d", i));
            check($sformatf("stv.stall%0d", i), 64'(wb_bus.stall_o), 64'(i == 7));
        end
        m_alu(5'd20, 32'h2000); exp_push(1'b1, 5'd9, 32'h99, 1'b1); step("stv.drain");
        check("stv.stall_drop", 64'(wb_bus.stall_o), 64'd0);
        exp_push(1'b1, 5'd20, 32'h2000, 1'b1); step("stv.resume");

        // Asynchronous reset with a full FIFO and a write in flight.
        m_alu(5'd21, 32'h2100); ll_set(1'b1, 5'd22, 32'h22); exp_push(1'b1, 5'd21, 32'h2100, 1'b1); step("ar.c1");
        m_alu(5'd23, 32'h2300); ll_set(1'b1, 5'd24, 32'h24); exp_push(1'b1, 5'd23, 32'h2300, 1'b1); step("ar.c2");
        check("ar.full", 64'(wb_bus.LL_ready_o), 64'd0);
        m_idle(); ll_set(1'b0, 5'd0, 32'h0);
        rst_i = 1'b1;
        #1;
        check("ar.need",  64'(wb_bus.MD_need_dstE_o), 64'd0);
        check("ar.dst",   64'(wb_bus.MD_dstE_o), 64'd0);
        check("ar.data",  64'(wb_bus.MD_data_o), 64'd0);
        check("ar.stall", 64'(wb_bus.stall_o), 64'd0);
        check("ar.ready", 64'(wb_bus.LL_ready_o), 64'd1);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        exp_push(1'b0, 5'd0, 32'h0, 1'b1); step("ar.post1");
        exp_push(1'b0, 5'd0, 32'h0, 1'b1); step("ar.post2");
        exp_push(1'b0, 5'd0, 32'h0, 1'b1); step("ar.post3");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
